fetch_stage: RTL and testbench

Instruction fetch stage of the 32-bit RISC-V core, directly upstream of decode and the immediate extender. Maintains the fetch PC, issues word reads to instruction memory over a single-outstanding req/ack handshake, and buffers returned words in a 2-entry FIFO. Presents `{instr, instr_pc}` to decode with a valid/ready handshake. Accepts PC redirects from branch/jump resolution, which flush the buffer.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request channel, redirect input,
// and the decode-facing instruction stream.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction fetch: single-outstanding imem requests feeding a
// 2-entry {pc, word} buffer, with redirect-driven flush and stale-ack dropping.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic        req_r, req_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] fetch_pc_r, fetch_pc_s;
   logic [31:0] pending_pc_r, pending_pc_s;
   logic [1:0]  count_r;
   logic [31:0] head_pc_r, head_word_r, tail_pc_r, tail_word_r;
   logic        push_s, flush_s, pop_s, ack_s;
   logic [2:0]  cnt_base_s;
   logic [31:0] redir_pc_s, drop_target_s;

   assign ack_s         = bus.imem_ack & req_r;
   assign pop_s         = (count_r != 2'd0) & bus.instr_ready;
   assign redir_pc_s    = bus.redirect_pc & ~32'h0000_0003;
   assign cnt_base_s    = {1'b0, count_r} - {2'b00, pop_s};
   assign drop_target_s = bus.redirect_valid ? redir_pc_s : pending_pc_r;

   assign bus.imem_req    = req_r;
   assign bus.imem_addr   = addr_r;
   assign bus.instr_valid = (count_r != 2'd0);
   assign bus.instr       = head_word_r;
   assign bus.instr_pc    = head_pc_r;

   // Next-state, request and buffer-control decisions
   always_comb begin
      state_s      = state_r;
      req_s        = req_r;
      addr_s       = addr_r;
      fetch_pc_s   = fetch_pc_r;
      pending_pc_s = pending_pc_r;
      push_s       = 1'b0;
      flush_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.redirect_valid) begin
               flush_s    = 1'b1;
               req_s      = 1'b1;
               addr_s     = redir_pc_s;
               fetch_pc_s = redir_pc_s;
               state_s    = ST_FETCH;
            end else if (cnt_base_s <= 3'd1) begin
               req_s   = 1'b1;
               addr_s  = fetch_pc_r;
               state_s = ST_FETCH;
            end else begin
               req_s   = 1'b0;
            end
         end
         ST_FETCH: begin
            if (bus.redirect_valid) begin
               flush_s = 1'b1;
               if (ack_s) begin
                  addr_s     = redir_pc_s;
                  fetch_pc_s = redir_pc_s;
               end else begin
                  pending_pc_s = redir_pc_s;
                  state_s      = ST_DROP;
               end
            end else if (ack_s) begin
               push_s     = 1'b1;
               fetch_pc_s = addr_r + 32'd4;
               // the returning word needs a free slot, so only re-issue with one left
               if ((cnt_base_s + 3'd1) <= 3'd1) begin
                  addr_s = addr_r + 32'd4;
               end else begin
                  req_s   = 1'b0;
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (bus.redirect_valid) begin
               flush_s      = 1'b1;
               pending_pc_s = redir_pc_s;
            end else begin
               flush_s      = 1'b0;
            end
            if (ack_s) begin
               req_s      = 1'b1;
               addr_s     = drop_target_s;
               fetch_pc_s = drop_target_s;
               state_s    = ST_FETCH;
            end else begin
               state_s    = ST_DROP;
            end
         end
         default: begin
            req_s   = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM, request and PC registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         req_r        <= 1'b0;
         addr_r       <= RESET_PC;
         fetch_pc_r   <= RESET_PC;
         pending_pc_r <= RESET_PC;
      end else begin
         state_r      <= state_s;
         req_r        <= req_s;
         addr_r       <= addr_s;
         fetch_pc_r   <= fetch_pc_s;
         pending_pc_r <= pending_pc_s;
      end
   end

   // Two-entry instruction buffer; head is zeroed whenever it becomes empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r     <= 2'd0;
         head_pc_r   <= 32'd0;
         head_word_r <= 32'd0;
         tail_pc_r   <= 32'd0;
         tail_word_r <= 32'd0;
      end else if (flush_s) begin
         count_r     <= 2'd0;
         head_pc_r   <= 32'd0;
         head_word_r <= 32'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               count_r <= count_r + 2'd1;
               if (count_r == 2'd0) begin
                  head_pc_r   <= addr_r;
                  head_word_r <= bus.imem_rdata;
               end else begin
                  tail_pc_r   <= addr_r;
                  tail_word_r <= bus.imem_rdata;
               end
            end
            2'b01: begin
               count_r <= count_r - 2'd1;
               if (count_r == 2'd2) begin
                  head_pc_r   <= tail_pc_r;
                  head_word_r <= tail_word_r;
               end else begin
                  head_pc_r   <= 32'd0;
                  head_word_r <= 32'd0;
               end
            end
            2'b11: begin
               if (count_r == 2'd2) begin
                  head_pc_r   <= tail_pc_r;
                  head_word_r <= tail_word_r;
                  tail_pc_r   <= addr_r;
                  tail_word_r <= bus.imem_rdata;
               end else begin
                  head_pc_r   <= addr_r;
                  head_word_r <= bus.imem_rdata;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory responder plus a queue-based
// model of the expected in-order instruction stream.
module tb_fetch_stage;

   logic clk;
   logic reset;
   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks;
   int          n_pass;
   int          pops;
   logic [31:0] q[$];
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   logic        drop_flag;
   logic [31:0] exp_fetch_pc;
   logic        exp_addr_chk;
   logic [31:0] exp_addr_val;
   logic        exp_inval_chk;
   logic        force_rdr;
   logic [31:0] force_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.imem_ack       = 1'b0;
      bus.redirect_valid = 1'b0;
      reset = 1'b1;
      #2;
      check_eq("rst_req",   64'(bus.imem_req), 64'd0);
      check_eq("rst_addr",  64'(bus.imem_addr), 64'h100);
      check_eq("rst_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("rst_head",  {bus.instr_pc, bus.instr}, 64'd0);
      reset = 1'b0;
      q.delete();
      mem_busy      = 1'b0;
      drop_flag     = 1'b0;
      exp_fetch_pc  = 32'h0000_0100;
      exp_addr_chk  = 1'b0;
      exp_inval_chk = 1'b0;
   endtask

   task automatic step(input int ready_pct, input int lat_max, input int redir_pct, input int spur_pct);
      logic        ack, rdy, rdr;
      logic [31:0] rpc, tgt, rdata;
      int          outstanding;
      @(negedge clk);
      if (exp_addr_chk) begin
         check_eq("redir_addr", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, exp_addr_val});
         exp_addr_chk = 1'b0;
      end
      if (exp_inval_chk) check_eq("flush_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("valid", 64'(bus.instr_valid), 64'(q.size() != 0));
      if (q.size() == 0) check_eq("empty_head", {bus.instr_pc, bus.instr}, 64'd0);
      else check_eq("head", {bus.instr_pc, bus.instr}, {q[0], mem_word(q[0])});
      outstanding = (bus.imem_req && !drop_flag) ? 1 : 0;
      check_eq("reserve", 64'((q.size() + outstanding) <= 2), 64'd1);
      if (!bus.imem_req) check_eq("idle_full", 64'(q.size()), 64'd2);

      ack   = 1'b0;
      rdata = $urandom;
      if (bus.imem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_wait = $urandom_range(0, lat_max);
            check_eq("req_addr", 64'(bus.imem_addr), 64'(exp_fetch_pc));
         end else begin
            check_eq("addr_hold", 64'(bus.imem_addr), 64'(mem_addr));
         end
         if (mem_wait == 0) begin
            ack   = 1'b1;
            rdata = mem_word(mem_addr);
         end else begin
            mem_wait--;
         end
      end else begin
         if (mem_busy) begin
            check_eq("req_held", 64'(bus.imem_req), 64'd1);
            mem_busy = 1'b0;
         end
         ack = ($urandom_range(0, 99) < spur_pct);
      end

      rdy = ($urandom_range(0, 99) < ready_pct);
      rdr = ($urandom_range(0, 99) < redir_pct);
      case ($urandom_range(0, 3))
         0:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         1:       rpc = 32'h0000_0200 + $urandom_range(0, 7);
         default: rpc = $urandom;
      endcase
      if (force_rdr) begin
         rdr       = 1'b1;
         rpc       = force_pc;
         force_rdr = 1'b0;
      end
      bus.imem_ack       = ack;
      bus.imem_rdata     = rdata;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rdr;
      bus.redirect_pc    = rpc;

      // expected effect of the coming edge
      exp_inval_chk = rdr;
      if (rdr) begin
         tgt = rpc & ~32'h0000_0003;
         q.delete();
         if (bus.imem_req && ack) mem_busy = 1'b0;
         drop_flag = bus.imem_req && !ack;
         if (!bus.imem_req || ack) begin
            exp_addr_chk = 1'b1;
            exp_addr_val = tgt;
         end
         exp_fetch_pc = tgt;
      end else begin
         if (bus.instr_valid && rdy) begin
            void'(q.pop_front());
            pops++;
         end
         if (bus.imem_req && ack) begin
            mem_busy = 1'b0;
            if (drop_flag) drop_flag = 1'b0;
            else begin
               q.push_back(mem_addr);
               exp_fetch_pc = mem_addr + 32'd4;
            end
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      n_checks = 0;
      n_pass = 0;
      pops = 0;
      force_rdr = 1'b0;
      force_pc = 32'd0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.instr_ready = 1'b0;
      do_reset();

      // streaming: zero-latency memory, decode always ready
      repeat (40) step(100, 0, 0, 0);
      check_eq("throughput", 64'(pops >= 38), 64'd1);

      // stall: two words buffered, no third request
      do_reset();
      repeat (8) step(0, 0, 0, 0);
      check_eq("stall_state", {62'd0, bus.instr_valid, bus.imem_req}, 64'd2);
      check_eq("stall_head", 64'(bus.instr_pc), 64'h100);
      repeat (6) step(100, 0, 0, 0);

      // redirect landing on an ack with unaligned target, then address wrap
      force_rdr = 1'b1;
      force_pc  = 32'h0000_0203;
      repeat (5) step(100, 0, 0, 0);
      force_rdr = 1'b1;
      force_pc  = 32'hFFFF_FFF4;
      repeat (8) step(100, 0, 0, 0);

      // redirect while a slow request is outstanding
      force_rdr = 1'b1;
      force_pc  = 32'h0000_0200;
      repeat (20) step(100, 3, 0, 0);

      pops = 0;
      repeat (3000) step(70, 3, 8, 10);
      check_eq("progress", 64'(pops > 100), 64'd1);

      // async reset with buffer filled and traffic in flight
      repeat (10) step(0, 2, 0, 0);
      do_reset();
      repeat (200) step(60, 2, 5, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
